iter_div_unit: RTL and testbench

- Multi-cycle RV32M divider in the EXE stage: DIV, DIVU, REM, REMU via a radix-2 restoring algorithm.
- Sits on the initiator side of the pipeline stall interface. It raises stall_req so the hazard logic holds IF/ID/EXE while it computes.
- Returns the result and its destination register in a one-cycle done pulse.
- Handles the RISC-V divide-by-zero and signed-overflow cases on a 1-cycle fast path.

---
 rtl/iter_div_unit.sv | 132 +++++++++++++
 tb/tb_iter_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module iter_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, result_q;
  logic [1:0]       op_q;
  logic [4:0]       rd_q, rd_out_q;
  logic             neg_q, neg_r;

  logic            signed_op, div_zero, ovf, accept;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] quo_fix, rem_fix, fin_val;

  // op[0]=0 selects the signed variants (DIV, REM)
  assign signed_op = ~op[0];
  assign a_abs     = (signed_op & dividend[XLEN-1]) ? -dividend : dividend;
  assign b_abs     = (signed_op & divisor[XLEN-1])  ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = signed_op & (dividend == INT_MIN) & (divisor == '1);
  assign accept    = (state == S_IDLE) & start & ~flush;

  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};

  assign quo_fix = neg_q ? -quo_q : quo_q;
  assign rem_fix = neg_r ? -rem_q : rem_q;
  assign fin_val = op_q[1] ? rem_fix : quo_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= op;
            rd_q <= rd_in;
            cnt  <= CNT_INIT;
            // Special cases park the final answer in quo/rem with no sign fix-up
            if (div_zero) begin
              quo_q <= '1;
              rem_q <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIN;
            end else if (ovf) begin
              quo_q <= INT_MIN;
              rem_q <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIN;
            end else begin
              quo_q  <= a_abs;
              rem_q  <= '0;
              dvsr_q <= b_abs;
              neg_q  <= signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
              neg_r  <= signed_op & dividend[XLEN-1];
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (!diff[XLEN]) begin
              rem_q <= diff[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= rem_sh[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= S_FIN;
          end
        end
        S_FIN: begin
          if (!flush) begin
            result_q <= fin_val;
            rd_out_q <= rd_q;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign stall_req = (start & (state == S_IDLE) & ~flush) | (state == S_CALC);
  assign done      = (state == S_FIN) & ~flush;
  assign result    = done ? fin_val : result_q;
  assign rd_out    = done ? rd_q : rd_out_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// tb/tb_iter_div_unit.sv - directed self-checking bench for iter_div_unit
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  iter_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a rising edge; that cycle is T0. Returns #1 after the edge ending T(lat).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat, input bit repulse);
    int done_n = 0;
    int done_t = -1;
    int stall_n = 0;
    logic [31:0] res = '0;
    logic [4:0]  rdv = '0;
    for (int t = 0; t <= lat; t++) begin
      start = (t == 0) || (repulse && (t == 5 || t == 20));
      if (t == 0) begin
        op = o; dividend = a; divisor = b; rd_in = rd;
      end else if (start) begin
        dividend = 32'd5; divisor = 32'd1; rd_in = 5'd31;
      end
      @(negedge clk);
      if (stall_req) stall_n++;
      if (done) begin
        done_n++; done_t = t; res = result; rdv = rd_out;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_cnt"}, done_n, 1);
    check({tag, "_latency"}, done_t, lat);
    check({tag, "_result"}, res, exp);
    check({tag, "_rd"}, {27'd0, rdv}, {27'd0, rd});
    check({tag, "_stall_cycles"}, stall_n, lat);
  endtask

  initial begin
    int done_n;
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    rd_in = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_rd_out", rd_out, 0);
    check("rst_stall", stall_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op("divu_100_7",  2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33, 0);
    do_op("remu_100_7",  2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 33, 0);
    do_op("div_m7_2",    2'b00, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFD, 33, 0);
    do_op("rem_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFF, 33, 0);
    do_op("div_7_m2",    2'b00, 32'd7, 32'hFFFFFFFE, 5'd9, 32'hFFFFFFFD, 33, 0);
    do_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFFFFFE, 5'd10, 32'd1, 33, 0);
    do_op("div_m100_m7", 2'b00, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd11, 32'd14, 33, 0);
    do_op("rem_m100_m7", 2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd12, 32'hFFFFFFFE, 33, 0);
    do_op("divu_by0",    2'b01, 32'd1234, 32'd0, 5'd13, 32'hFFFFFFFF, 1, 0);
    do_op("rem_by0",     2'b10, 32'hFFFFFF85, 32'd0, 5'd14, 32'hFFFFFF85, 1, 0);
    do_op("div_ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1, 0);
    do_op("rem_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 1, 0);

    // start together with flush in IDLE must be ignored
    start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd10; divisor = 32'd2; rd_in = 5'd3;
    @(negedge clk);
    check("flush_start_stall", stall_req, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", busy, 0);
    @(posedge clk); #1;

    // flush during CALC at T10
    done_n = 0;
    for (int t = 0; t <= 11; t++) begin
      start = (t == 0);
      flush = (t == 10);
      if (t == 0) begin
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd20;
      end
      @(negedge clk);
      if (done) done_n++;
      if (t == 11) check("flush_idle_t11", busy, 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check("flush_no_done", done_n, 0);
    do_op("after_flush_9_3", 2'b01, 32'd9, 32'd3, 5'd21, 32'd3, 33, 0);

    do_op("repulse_100_7", 2'b01, 32'd100, 32'd7, 5'd22, 32'd14, 33, 1);
    do_op("b2b_divu_1000_3", 2'b01, 32'd1000, 32'd3, 5'd23, 32'd333, 33, 0);
    do_op("b2b_remu_1000_3", 2'b11, 32'd1000, 32'd3, 5'd24, 32'd1, 33, 0);

    // reset at T15 mid-operation
    done_n = 0;
    for (int t = 0; t <= 16; t++) begin
      start = (t == 0);
      rst = (t == 15);
      if (t == 0) begin
        op = 2'b01; dividend = 32'd50000; divisor = 32'd7; rd_in = 5'd25;
      end
      @(negedge clk);
      if (done) done_n++;
      if (t == 16) begin
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_rd_out", rd_out, 0);
        check("midrst_stall", stall_req, 0);
      end
      @(posedge clk); #1;
    end
    check("midrst_no_done", done_n, 0);
    do_op("after_rst_50000_7", 2'b01, 32'd50000, 32'd7, 5'd26, 32'd7142, 33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
